router_pkt_gen: RTL and testbench

ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

---
 rtl/router_pkt_gen.sv | 163 ++++++++++++++++
 tb/tb_router_pkt_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_gen.sv
// Packet generator for the router: emits a {len,addr} header, LFSR payload bytes and
// a running-XOR parity byte, honouring the router's busy stall on every byte.
//
//   state   | meaning
//   IDLE    | waiting for a command; data_out = 0
//   HEADER  | header byte {len,addr} presented, pkt_valid = 1
//   PAYLOAD | LFSR payload bytes presented, pkt_valid = 1
//   PARITY  | parity byte presented, pkt_valid = 0
//   DONE    | one-cycle done pulse, then back to IDLE
module router_pkt_gen #(
    parameter int unsigned MAX_LEN  = 63,
    parameter logic [1:0]  BAD_ADDR = 2'b11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic [7:0] seed,
    input  logic       corrupt_parity,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       done,
    output logic       active,
    output logic       invalid_cmd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_DONE
    } state_t;

    localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] parity_q, parity_d;
    logic       corrupt_q, corrupt_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic [7:0] data_out_q, data_out_d;
    logic       done_q, done_d;
    logic       active_q, active_d;
    logic       invalid_q, invalid_d;

    logic       cmd_ok;
    logic [7:0] lfsr_next;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        parity_d  = parity_q;
        corrupt_d = corrupt_q;
        invalid_d = 1'b0;

        cmd_ok    = (dest_addr != BAD_ADDR) && (payload_len != 6'd0) &&
                    (payload_len <= MAX_LEN_W);
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd_ok) begin
                        addr_d    = dest_addr;
                        len_d     = payload_len;
                        // an all-zero seed would lock the LFSR at zero
                        lfsr_d    = (seed == 8'h00) ? 8'h01 : seed;
                        corrupt_d = corrupt_parity;
                        cnt_d     = 6'd0;
                        parity_d  = 8'h00;
                        state_d   = S_HEADER;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    parity_d = parity_q ^ {len_q, addr_q};
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ lfsr_q;
                    lfsr_d   = lfsr_next;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == len_q) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // outputs are registered, so they are decoded from the next state
        pkt_valid_d = (state_d == S_HEADER) || (state_d == S_PAYLOAD);
        active_d    = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        case (state_d)
            S_HEADER:  data_out_d = {len_d, addr_d};
            S_PAYLOAD: data_out_d = lfsr_d;
            S_PARITY:  data_out_d = parity_d ^ {8{corrupt_d}};
            default:   data_out_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            cnt_q       <= 6'd0;
            lfsr_q      <= 8'h00;
            parity_q    <= 8'h00;
            corrupt_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= 8'h00;
            done_q      <= 1'b0;
            active_q    <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            parity_q    <= parity_d;
            corrupt_q   <= corrupt_d;
            pkt_valid_q <= pkt_valid_d;
            data_out_q  <= data_out_d;
            done_q      <= done_d;
            active_q    <= active_d;
            invalid_q   <= invalid_d;
        end
    end

    assign pkt_valid   = pkt_valid_q;
    assign data_out    = data_out_q;
    assign done        = done_q;
    assign active      = active_q;
    assign invalid_cmd = invalid_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Scoreboard bench for router_pkt_gen: stimulus queues expected output beats, a
// negedge monitor compares every cycle the generator is (or just was) active.
module tb_router_pkt_gen;

    logic       clock;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic [7:0] seed;
    logic       corrupt_parity;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       done;
    logic       active;
    logic       invalid_cmd;

    int vectors     = 0;
    int miscompares = 0;

    // beat = {pkt_valid, done, invalid_cmd, active, data_out}
    logic [11:0] exp_q[$];
    logic        prev_active = 1'b0;

    router_pkt_gen dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .dest_addr     (dest_addr),
        .payload_len   (payload_len),
        .seed          (seed),
        .corrupt_parity(corrupt_parity),
        .busy          (busy),
        .pkt_valid     (pkt_valid),
        .data_out      (data_out),
        .done          (done),
        .active        (active),
        .invalid_cmd   (invalid_cmd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic push_data(input logic [7:0] d);
        exp_q.push_back({4'b1001, d});
    endtask

    task automatic push_par(input logic [7:0] d);
        exp_q.push_back({4'b0001, d});
    endtask

    task automatic push_done_idle();
        exp_q.push_back({4'b0101, 8'h00});
        exp_q.push_back(12'h000);
    endtask

    task automatic push_invalid();
        exp_q.push_back({4'b0010, 8'h00});
    endtask

    // Hand-computed packet for len=5 addr=2 seed=0x01
    task automatic push_pkt5(input logic [7:0] par);
        push_data(8'h16);
        push_data(8'h01);
        push_data(8'h02);
        push_data(8'h04);
        push_data(8'h08);
        push_data(8'h11);
        push_par(par);
        push_done_idle();
    endtask

    // Monitor
    always @(negedge clock) begin
        logic [11:0] got;
        logic [11:0] e;
        if (active === 1'b1 || invalid_cmd === 1'b1 || prev_active) begin
            got = {pkt_valid, done, invalid_cmd, active, data_out};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat @%0t: got pv=%b done=%b inv=%b act=%b data=%h, required no beat",
                         $time, got[11], got[10], got[9], got[8], got[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL beat @%0t: got pv=%b done=%b inv=%b act=%b data=%h, required pv=%b done=%b inv=%b act=%b data=%h",
                             $time, got[11], got[10], got[9], got[8], got[7:0],
                             e[11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
        prev_active = (active === 1'b1);
    end

    task automatic check_idle(input string name);
        logic [11:0] got;
        got = {pkt_valid, done, invalid_cmd, active, data_out};
        vectors++;
        if (got !== 12'h000) begin
            miscompares++;
            $display("FAIL %s: got pv=%b done=%b inv=%b act=%b data=%h, required all zero",
                     name, got[11], got[10], got[9], got[8], got[7:0]);
        end
    endtask

    task automatic issue(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                         input logic c);
        start          = 1'b1;
        dest_addr      = a;
        payload_len    = l;
        seed           = s;
        corrupt_parity = c;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d beats still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] s;
        logic [7:0] par;

        reset          = 1'b1;
        start          = 1'b0;
        dest_addr      = 2'd0;
        payload_len    = 6'd0;
        seed           = 8'h00;
        corrupt_parity = 1'b0;
        busy           = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle("reset_state");
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic packet
        push_pkt5(8'h08);
        issue(2'd2, 6'd5, 8'h01, 1'b0);
        drain("basic", 30);

        // Stall for 3 cycles while 0x02 is presented
        push_data(8'h16);
        push_data(8'h01);
        repeat (4) push_data(8'h02);
        push_data(8'h04);
        push_data(8'h08);
        push_data(8'h11);
        push_par(8'h08);
        push_done_idle();
        issue(2'd2, 6'd5, 8'h01, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1 busy = 1'b1;
        repeat (3) @(posedge clock);
        #1 busy = 1'b0;
        drain("stall", 30);

        // Corrupted parity, plus an illegal start mid-packet that must be ignored
        push_pkt5(8'hF7);
        issue(2'd2, 6'd5, 8'h01, 1'b1);
        @(posedge clock);
        #1;
        start = 1'b1; dest_addr = 2'd3; payload_len = 6'd0; corrupt_parity = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        drain("corrupt", 30);

        // Rejected commands
        push_invalid();
        issue(2'd3, 6'd5, 8'h01, 1'b0);
        drain("bad_addr", 10);
        push_invalid();
        issue(2'd0, 6'd0, 8'h01, 1'b0);
        drain("zero_len", 10);

        // Reset during the third payload byte; reset wins over a concurrent start
        push_data(8'h16);
        push_data(8'h01);
        push_data(8'h02);
        push_data(8'h04);
        exp_q.push_back(12'h000);
        issue(2'd2, 6'd5, 8'h01, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b1; dest_addr = 2'd2; payload_len = 6'd5; seed = 8'h00;
        corrupt_parity = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check_idle("reset_priority");
        push_pkt5(8'h08);
        reset = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        drain("after_reset", 30);

        // Max length, start held high: two identical packets with one IDLE cycle
        for (int p = 0; p < 2; p++) begin
            s   = 8'hA5;
            par = 8'hFC;
            push_data(8'hFC);
            for (int i = 0; i < 63; i++) begin
                push_data(s);
                par = par ^ s;
                s   = lfsr_step(s);
            end
            push_par(par);
            push_done_idle();
        end
        start = 1'b1; dest_addr = 2'd0; payload_len = 6'd63; seed = 8'hA5;
        corrupt_parity = 1'b0;
        repeat (68) @(posedge clock);
        #1 start = 1'b0;
        drain("max_len", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
